fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Front-end stage directly upstream of instructionmemory.
- Owns the 10-bit word-indexed program counter and drives it to instructionmemory.pc.
- Selects the next PC: sequential, branch, jump or jump-register.
- Captures the returned instruction into the IF/ID pipeline register, with stall, flush-on-redirect and halt handling.

Parameters:
- PC_W, 10, program counter width; word index into instruction memory.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- CNT_W, 16, fetch counter width.

Ports:
- CLK_SYS  in  1  system clock; all state updates on its rising edge.
- RST_SYS_N  in  1  synchronous, active-low reset.
- stall  in  1  hazard stall from decode; hold PC and IF/ID.
- branch_taken  in  1  conditional branch resolved taken in ID.
- branch_offset  in  16  signed word offset, relative to ifid_pc_plus1.
- jump  in  1  J/JAL redirect.
- jump_target  in  26  word-index jump target.
- jump_reg  in  1  JR redirect.
- jr_target  in  32  register byte address for JR.
- instruction  in  INSTR_W  instructionmemory output for the current pc; combinational, same cycle.
- pc  out  PC_W  fetch address to instructionmemory.
- ifid_instruction  out  INSTR_W  IF/ID instruction.
- ifid_pc_plus1  out  PC_W  IF/ID PC+1.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped on HALT_WORD.
- fetch_count  out  CNT_W  count of instructions accepted into IF/ID.

Behaviour:
- All transitions happen on the CLK_SYS rising edge.
- Reset applies when RST_SYS_N=0 at the edge. It overrides everything, including mid-redirect or halted state.
  - pc=RESET_PC, ifid_instruction=0, ifid_pc_plus1=0, ifid_valid=0, halted=0, fetch_count=0.
  - state=BOOT.
- States:
  - BOOT: lasts exactly one cycle after reset is released. pc is held and IF/ID stays a bubble so the memory output settles. Next state is RUN unconditionally.
  - RUN: normal fetch.
  - HALT: entered from RUN when an instruction equal to HALT_WORD is accepted into IF/ID. pc freezes and IF/ID loads bubbles from the following cycle. halted=1 registered. Exit is by reset only; redirects and stall are ignored.
- Redirect targets, all truncated to PC_W (modulo 2^PC_W):
  - jr: jr_target[11:2]
  - jump: jump_target[9:0]
  - branch: ifid_pc_plus1 + sign-extended branch_offset
- Priority in RUN, highest first:
  1. jump_reg
  2. jump
  3. branch_taken
  4. stall
  5. sequential
- Redirect (any of the three), even when stall=1:
  - pc <= target.
  - IF/ID loads a bubble: ifid_valid=0, ifid_instruction=0, ifid_pc_plus1=0.
  - fetch_count does not increment.
- Stall with no redirect: pc, IF/ID and fetch_count hold their values.
- Sequential:
  - pc <= pc+1; wraps 1023->0.
  - ifid_instruction <= instruction, ifid_pc_plus1 <= pc+1 (wrapped), ifid_valid <= 1.
  - fetch_count increments, saturating at all-ones.
- HALT_WORD acceptance:
  - The halt instruction itself is latched into IF/ID with valid=1 and counted.
  - pc still advances once on that edge.
  - No further acceptance after it.
- Latency: instruction at address A appears in IF/ID one edge after pc=A, provided there is no stall or redirect.
- Multiple redirect inputs asserted together: the priority order above resolves them; no error is flagged.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_W, INSTR_W, NOP_WORD=0, HALT_WORD
  - fetch state enum {FETCH_BOOT, FETCH_RUN, FETCH_HALT}
- One sub-module is natural: next_pc_sel, a combinational target computation plus priority mux.
- The state register, PC register, IF/ID register and counter stay in fetch_unit.

Test Plan:
- Reset, then release with a sequential program:
  - pc is 0 for BOOT plus the first RUN cycle, then 1, 2, 3.
  - ifid_valid first rises the edge after BOOT, with ifid_pc_plus1=1.
  - fetch_count=3 after three accepts.
- stall=1 for 2 cycles at pc=5: pc and IF/ID are unchanged for 2 edges, then pc resumes at 6 and fetch_count is unchanged during the stall.
- Branch with ifid_pc_plus1=8 and branch_offset=16'hFFFC (−4): next pc=4, IF/ID is a bubble (valid=0), fetch_count is unchanged.
- Simultaneous redirects:
  - jump=1 (target 26'd100), branch_taken=1 and stall=1 together: pc=100.
  - jump_reg=1 with jr_target=32'h0000_0050 and jump=1 together: pc=20.
- Wrap: pc=1023 sequential -> pc=0 and ifid_pc_plus1=0.
- HALT_WORD at address 7:
  - IF/ID gets it with valid=1, then halted=1.
  - pc stays 8 and IF/ID shows bubbles even under jump=1.
  - Reset mid-halt returns pc=0 and halted=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, special instruction encodings
// and the fetch-stage state encoding.
package cpu_pkg;

   localparam int          PC_W      = 10;
   localparam int          INSTR_W   = 32;
   localparam int          CNT_W     = 16;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
   localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      FETCH_BOOT = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC selection: redirect target computation and the
// jr > jump > branch > stall > sequential priority mux.
module next_pc_sel #(
   parameter int PC_W = cpu_pkg::PC_W
) (
   input  logic               [PC_W-1:0] pc,
   input  logic               [PC_W-1:0] ifid_pc_plus1,
   input  logic                          stall,
   input  logic                          branch_taken,
   input  logic signed        [15:0]     branch_offset,
   input  logic                          jump,
   input  logic               [25:0]     jump_target,
   input  logic                          jump_reg,
   input  logic               [31:0]     jr_target,
   output logic               [PC_W-1:0] next_pc,
   output logic               [PC_W-1:0] pc_plus1,
   output logic                          redirect,
   output logic                          advance
);
   import cpu_pkg::*;

   logic [PC_W-1:0] br_target;

   // Sign-extending cast then truncating add gives the modulo-2^PC_W target
   assign br_target = ifid_pc_plus1 + PC_W'(branch_offset);
   assign pc_plus1  = pc + 1'b1;

   always_comb begin
      next_pc  = pc;
      redirect = 1'b0;
      advance  = 1'b0;
      if (jump_reg) begin
         next_pc  = jr_target[PC_W+1:2];
         redirect = 1'b1;
      end else if (jump) begin
         next_pc  = jump_target[PC_W-1:0];
         redirect = 1'b1;
      end else if (branch_taken) begin
         next_pc  = br_target;
         redirect = 1'b1;
      end else if (!stall) begin
         next_pc  = pc_plus1;
         advance  = 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, the IF/ID register, the
// boot/run/halt control and the accepted-instruction counter.
module fetch_unit #(
   parameter int                       PC_W      = cpu_pkg::PC_W,
   parameter int                       INSTR_W   = cpu_pkg::INSTR_W,
   parameter logic [PC_W-1:0]          RESET_PC  = '0,
   parameter logic [INSTR_W-1:0]       HALT_WORD = cpu_pkg::HALT_WORD,
   parameter int                       CNT_W     = cpu_pkg::CNT_W
) (
   input  logic                 CLK_SYS,
   input  logic                 RST_SYS_N,
   input  logic                 stall,
   input  logic                 branch_taken,
   input  logic signed [15:0]   branch_offset,
   input  logic                 jump,
   input  logic [25:0]          jump_target,
   input  logic                 jump_reg,
   input  logic [31:0]          jr_target,
   input  logic [INSTR_W-1:0]   instruction,
   output logic [PC_W-1:0]      pc,
   output logic [INSTR_W-1:0]   ifid_instruction,
   output logic [PC_W-1:0]      ifid_pc_plus1,
   output logic                 ifid_valid,
   output logic                 halted,
   output logic [CNT_W-1:0]     fetch_count
);
   import cpu_pkg::*;

   fetch_state_e    state, state_nxt;
   logic [PC_W-1:0] next_pc, pc_plus1;
   logic            redirect, advance, accept, accept_halt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   next_pc_sel #(.PC_W(PC_W)) u_next_pc_sel (
      .pc            (pc),
      .ifid_pc_plus1 (ifid_pc_plus1),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_target   (jump_target),
      .jump_reg      (jump_reg),
      .jr_target     (jr_target),
      .next_pc       (next_pc),
      .pc_plus1      (pc_plus1),
      .redirect      (redirect),
      .advance       (advance)
   );

   assign accept      = (state == FETCH_RUN) && advance;
   assign accept_halt = accept && (instruction == HALT_WORD);

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH_BOOT: state_nxt = FETCH_RUN;
         FETCH_RUN:  if (accept_halt) state_nxt = FETCH_HALT;
         FETCH_HALT: state_nxt = FETCH_HALT;
         default:    state_nxt = FETCH_BOOT;
      endcase
   end

   always_ff @(posedge CLK_SYS) begin
      if (!RST_SYS_N) state <= FETCH_BOOT;
      else            state <= state_nxt;
   end

   // PC, IF/ID and counter; BOOT holds everything, HALT keeps feeding bubbles
   always_ff @(posedge CLK_SYS) begin
      if (!RST_SYS_N) begin
         pc               <= RESET_PC;
         ifid_instruction <= INSTR_W'(NOP_WORD);
         ifid_pc_plus1    <= '0;
         ifid_valid       <= 1'b0;
         halted           <= 1'b0;
         fetch_count      <= '0;
      end else if (state == FETCH_RUN) begin
         pc <= next_pc;
         if (redirect) begin
            ifid_instruction <= INSTR_W'(NOP_WORD);
            ifid_pc_plus1    <= '0;
            ifid_valid       <= 1'b0;
         end else if (accept) begin
            ifid_instruction <= instruction;
            ifid_pc_plus1    <= pc_plus1;
            ifid_valid       <= 1'b1;
            fetch_count      <= sat_inc(fetch_count);
            halted           <= accept_halt;
         end
      end else if (state == FETCH_HALT) begin
         ifid_instruction <= INSTR_W'(NOP_WORD);
         ifid_pc_plus1    <= '0;
         ifid_valid       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized redirect/stall
// traffic compared every cycle against a spec-level reference model.
module tb_fetch_unit;

   logic               CLK_SYS = 1'b0;
   logic               RST_SYS_N;
   logic               stall, branch_taken, jump, jump_reg;
   logic signed [15:0] branch_offset;
   logic [25:0]        jump_target;
   logic [31:0]        jr_target;
   logic [31:0]        instruction;
   logic [9:0]         pc;
   logic [31:0]        ifid_instruction;
   logic [9:0]         ifid_pc_plus1;
   logic               ifid_valid, halted;
   logic [15:0]        fetch_count;

   logic [31:0] mem [1024];
   int          n_checks = 0;
   int          n_errors = 0;

   // Reference model state (mode: 0 boot, 1 run, 2 halt)
   int          m_mode, m_pc, m_pp1, m_count;
   logic [31:0] m_instr;
   bit          m_valid, m_halted;
   int          saved_count;

   always #5 CLK_SYS = ~CLK_SYS;
   assign instruction = mem[pc];

   fetch_unit dut (
      .CLK_SYS          (CLK_SYS),
      .RST_SYS_N        (RST_SYS_N),
      .stall            (stall),
      .branch_taken     (branch_taken),
      .branch_offset    (branch_offset),
      .jump             (jump),
      .jump_target      (jump_target),
      .jump_reg         (jump_reg),
      .jr_target        (jr_target),
      .instruction      (instruction),
      .pc               (pc),
      .ifid_instruction (ifid_instruction),
      .ifid_pc_plus1    (ifid_pc_plus1),
      .ifid_valid       (ifid_valid),
      .halted           (halted),
      .fetch_count      (fetch_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step();
      if (!RST_SYS_N) begin
         m_mode = 0; m_pc = 0; m_pp1 = 0; m_instr = 0;
         m_valid = 0; m_halted = 0; m_count = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 2) begin
         m_valid = 0; m_instr = 0; m_pp1 = 0;
      end else if (jump_reg || jump || branch_taken) begin
         if (jump_reg)  m_pc = (jr_target / 4) % 1024;
         else if (jump) m_pc = jump_target % 1024;
         else           m_pc = ((m_pp1 + int'(branch_offset)) % 1024 + 1024) % 1024;
         m_valid = 0; m_instr = 0; m_pp1 = 0;
      end else if (!stall) begin
         m_instr = mem[m_pc];
         m_pp1   = (m_pc + 1) % 1024;
         m_valid = 1;
         if (m_count < 65535) m_count = m_count + 1;
         if (m_instr == 32'hFFFF_FFFF) begin
            m_mode = 2; m_halted = 1;
         end
         m_pc = m_pp1;
      end
   endtask

   task automatic compare_all();
      check("pc", pc, m_pc);
      check("ifid_instruction", ifid_instruction, m_instr);
      check("ifid_pc_plus1", ifid_pc_plus1, m_pp1);
      check("ifid_valid", ifid_valid, m_valid);
      check("halted", halted, m_halted);
      check("fetch_count", fetch_count, m_count);
   endtask

   task automatic tick();
      @(posedge CLK_SYS);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle_inputs();
      stall = 0; branch_taken = 0; jump = 0; jump_reg = 0;
      branch_offset = 0; jump_target = 0; jr_target = 0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i] = $urandom;
         if (mem[i] == 32'hFFFF_FFFF) mem[i] = 32'h1234_5678;
      end
      idle_inputs();
      RST_SYS_N = 0;
      m_mode = 0; m_pc = 0; m_pp1 = 0; m_instr = 0;
      m_valid = 0; m_halted = 0; m_count = 0;
      tick(); tick();
      check("reset_pc", pc, 10'd0);
      check("reset_valid", ifid_valid, 1'b0);

      // Boot cycle then sequential fetch
      RST_SYS_N = 1;
      tick();
      check("boot_pc_held", pc, 10'd0);
      check("boot_bubble", ifid_valid, 1'b0);
      tick();
      check("first_pc", pc, 10'd1);
      check("first_valid", ifid_valid, 1'b1);
      check("first_pp1", ifid_pc_plus1, 10'd1);
      check("first_instr", ifid_instruction, mem[0]);
      tick(); tick();
      check("seq_pc3", pc, 10'd3);
      check("seq_count3", fetch_count, 16'd3);
      tick(); tick();

      // Two-cycle stall at pc=5
      stall = 1;
      tick(); tick();
      check("stall_pc", pc, 10'd5);
      check("stall_count", fetch_count, 16'd5);
      check("stall_ifid_pp1", ifid_pc_plus1, 10'd5);
      stall = 0;
      tick();
      check("resume_pc", pc, 10'd6);

      // Backward branch from ifid_pc_plus1=8
      tick(); tick();
      check("pre_branch_pp1", ifid_pc_plus1, 10'd8);
      saved_count = fetch_count;
      branch_taken = 1; branch_offset = 16'shFFFC;
      tick();
      check("branch_pc", pc, 10'd4);
      check("branch_bubble", ifid_valid, 1'b0);
      check("branch_count", fetch_count, saved_count);

      // Simultaneous redirects
      jump = 1; jump_target = 26'd100; stall = 1;
      tick();
      check("jump_over_branch", pc, 10'd100);
      idle_inputs();
      jump_reg = 1; jr_target = 32'h0000_0050; jump = 1; jump_target = 26'd300;
      tick();
      check("jr_over_jump", pc, 10'd20);

      // Wrap at top of memory
      idle_inputs();
      jump = 1; jump_target = 26'd1023;
      tick();
      check("wrap_pre_pc", pc, 10'd1023);
      jump = 0;
      tick();
      check("wrap_pc", pc, 10'd0);
      check("wrap_pp1", ifid_pc_plus1, 10'd0);

      // Randomized redirect and stall traffic
      for (int i = 0; i < 400; i++) begin
         stall         = ($urandom_range(3) == 0);
         branch_taken  = ($urandom_range(7) == 0);
         jump          = ($urandom_range(15) == 0);
         jump_reg      = ($urandom_range(15) == 0);
         branch_offset = 16'($urandom);
         jump_target   = 26'($urandom);
         jr_target     = $urandom;
         tick();
      end

      // Halt at address 7
      idle_inputs();
      mem[7] = 32'hFFFF_FFFF;
      jump = 1; jump_target = 26'd7;
      tick();
      jump = 0;
      tick();
      check("halt_latched", ifid_instruction, 32'hFFFF_FFFF);
      check("halt_valid", ifid_valid, 1'b1);
      check("halt_pc", pc, 10'd8);
      check("halted_set", halted, 1'b1);
      jump = 1; jump_target = 26'd55; stall = 1;
      tick(); tick(); tick();
      check("halt_pc_frozen", pc, 10'd8);
      check("halt_bubble", ifid_valid, 1'b0);
      check("halt_sticky", halted, 1'b1);
      idle_inputs();
      RST_SYS_N = 0;
      tick();
      check("halt_reset_pc", pc, 10'd0);
      check("halt_reset_halted", halted, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
